// File: rtl/sr_bank_driver.sv
// sr_bank_driver
//   Write-side controller for a bank of N clocked SR flip-flops. It accepts a
//   target word over a valid/ready handshake and turns it into per-bit set/reset
//   excitation. It then reads the bank back through q_fb_i and compares it with
//   the target. On a mismatch it re-drives the bank up to MAX_RETRY more times.
//
//   Optional build macro: SR_DRV_RETRY_CNT_EN adds the retry_cnt_o output.
//
// Ports
//   clk_i        rising-edge clock, shared with the SR bank
//   rst_i        asynchronous, active-high reset
//   req_valid_i  target word offered
//   req_ready_o  driver idle; request accepted on valid & ready at posedge
//   req_data_i   [N] target value for the bank
//   s_o, r_o     [N] set / reset lines to the bank
//   q_fb_i       [N] q outputs of the bank
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse: bank verified equal to target
//   err_o        one-cycle pulse: retries exhausted, bank differs from target
//   retry_cnt_o  (SR_DRV_RETRY_CNT_EN only) re-drives used by the last request
//
// State  | meaning
// IDLE   | ready for a request, s/r idle
// DRIVE  | s/r asserted for PULSE_CYCLES cycles
// SETTLE | s=r=0 for SETTLE_CYCLES cycles, waiting for the bank to settle
// CHECK  | compare q_fb with the target, then finish or retry
// DONE   | done pulse, retry count cleared
// ERR    | err pulse, retry count cleared
module sr_bank_driver #(
    parameter int N             = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 2,
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [N-1:0] req_data_i,
    output logic [N-1:0] s_o,
    output logic [N-1:0] r_o,
    input  logic [N-1:0] q_fb_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
`ifdef SR_DRV_RETRY_CNT_EN
    ,
    output logic [RCW-1:0] retry_cnt_o
`endif
);

    localparam int CMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]  PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0]  SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [RCW-1:0] RETRY_MAX   = RCW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, DRIVE, SETTLE, CHECK, DONE, ERR
    } state_t;

    state_t         state_q;
    logic [N-1:0]   tgt_q;
    logic [CW-1:0]  cnt_q;
    logic [RCW-1:0] retry_q;
    logic [N-1:0]   s_q, r_q;
    logic           ready_q, busy_q, done_q, err_q;

    // In IDLE the excitation comes from the incoming word. In CHECK it comes
    // from the latched target. Set and reset are mutually exclusive per bit by
    // construction.
    logic [N-1:0] tgt_src;
    logic [N-1:0] set_d, rst_d;

    always_comb begin
        tgt_src = (state_q == IDLE) ? req_data_i : tgt_q;
        set_d   = tgt_src & ~q_fb_i;
        rst_d   = ~tgt_src & q_fb_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
            s_q     <= '0;
            r_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        tgt_q   <= req_data_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if ((set_d | rst_d) == '0) begin
                            // Bank already holds the target: skip straight to DONE.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRIVE;
                            s_q     <= set_d;
                            r_q     <= rst_d;
                            cnt_q   <= PULSE_LOAD;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        state_q <= SETTLE;
                        s_q     <= '0;
                        r_q     <= '0;
                        cnt_q   <= SETTLE_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                CHECK: begin
                    if (q_fb_i == tgt_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (retry_q < RETRY_MAX) begin
                        state_q <= DRIVE;
                        retry_q <= retry_q + RCW'(1);
                        s_q     <= set_d;
                        r_q     <= rst_d;
                        cnt_q   <= PULSE_LOAD;
                    end else begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    retry_q <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    s_q     <= '0;
                    r_q     <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_DRV_RETRY_CNT_EN
    // Snapshot of the re-drives used. It is captured as DONE/ERR is entered,
    // held until the next accept, and cleared on that accept.
    logic [RCW-1:0] retry_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_cnt_q <= '0;
        end else if (state_q == IDLE && req_valid_i) begin
            retry_cnt_q <= '0;
        end else if (state_q == CHECK &&
                     (q_fb_i == tgt_q || retry_q == RETRY_MAX)) begin
            retry_cnt_q <= retry_q;
        end
    end

    assign retry_cnt_o = retry_cnt_q;
`endif

    assign s_o         = s_q;
    assign r_o         = r_q;
    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
module tb_sr_bank_driver;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int S  = 1;
    localparam int MR = 2;
    localparam int L  = P + S + 1;   // cycles per drive attempt incl. check

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [N-1:0] req_data_i;
    logic [N-1:0] s_o, r_o, q_fb_i;
    logic         busy_o, done_o, err_o;
`ifdef SR_DRV_RETRY_CNT_EN
    logic [1:0]   retry_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    sr_bank_driver #(.N(N), .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .MAX_RETRY(MR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i), .s_o(s_o), .r_o(r_o), .q_fb_i(q_fb_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
`ifdef SR_DRV_RETRY_CNT_EN
        , .retry_cnt_o(retry_cnt_o)
`endif
    );

    // Plant: bank of SR flip-flops, optional stuck-at-0 bits, TB preload port.
    logic [N-1:0] bank, stuck0, load_val;
    logic         load_en;
    assign q_fb_i = bank & ~stuck0;
    always @(posedge clk_i) begin
        if (load_en) bank <= load_val;
        else         bank <= (bank | s_o) & ~r_o;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: list of drive attempts derived from the target and bank.
    logic [N-1:0] m_s [0:MR];
    logic [N-1:0] m_r [0:MR];
    int           m_k, m_T;
    bit           m_ok;

    task automatic predict(input logic [N-1:0] q0, input logic [N-1:0] t);
        logic [N-1:0] q, sv, rv;
        q = q0; m_k = 0; m_ok = 0;
        if (((t & ~q) | (~t & q)) == '0) begin
            m_ok = 1;
        end else begin
            for (int a = 0; a <= MR; a++) begin
                if (!m_ok) begin
                    sv = t & ~q;
                    rv = ~t & q;
                    m_s[a] = sv;
                    m_r[a] = rv;
                    q = ((q | sv) & ~rv) & ~stuck0;
                    m_k++;
                    if (q == t) m_ok = 1;
                end
            end
        end
        m_T = 1 + m_k * L;
    endtask

    function automatic logic [N-1:0] exp_drive(input int c, input bit want_s);
        exp_drive = '0;
        for (int j = 0; j < m_k; j++)
            if (c >= 1 + j * L && c < 1 + j * L + P)
                exp_drive = want_s ? m_s[j] : m_r[j];
    endfunction

    task automatic load_bank(input logic [N-1:0] v);
        load_en = 1'b1; load_val = v;
        @(negedge clk_i);
        load_en = 1'b0;
    endtask

    // Issue one request at a negedge. Every cycle up to and including the first
    // idle cycle after DONE/ERR is checked, and the task returns at that cycle.
    task automatic run_req(input string nm, input logic [N-1:0] d, input bit hold);
        logic [N-1:0] q0;
        q0 = q_fb_i;
        predict(q0, d);
        req_valid_i = 1'b1; req_data_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
        if (!hold) req_valid_i = 1'b0;
        for (int c = 1; c <= m_T; c++) begin
            req_data_i = N'($urandom);
            chk({nm, ".s"},     32'(s_o),         32'(exp_drive(c, 1'b1)));
            chk({nm, ".r"},     32'(r_o),         32'(exp_drive(c, 1'b0)));
            chk({nm, ".s&r"},   32'(s_o & r_o),   32'(0));
            chk({nm, ".busy"},  32'(busy_o),      32'(1));
            chk({nm, ".ready"}, 32'(req_ready_o), 32'(0));
            chk({nm, ".done"},  32'(done_o),      32'(c == m_T && m_ok));
            chk({nm, ".err"},   32'(err_o),       32'(c == m_T && !m_ok));
`ifdef SR_DRV_RETRY_CNT_EN
            if (c == m_T)
                chk({nm, ".retry_cnt"}, 32'(retry_cnt_o), 32'(m_k == 0 ? 0 : m_k - 1));
`endif
            @(negedge clk_i);
        end
        chk({nm, ".idle_busy"},  32'(busy_o),      32'(0));
        chk({nm, ".idle_ready"}, 32'(req_ready_o), 32'(1));
        chk({nm, ".idle_done"},  32'(done_o | err_o), 32'(0));
        if (m_ok) chk({nm, ".bank"}, 32'(q_fb_i), 32'(d));
`ifdef SR_DRV_RETRY_CNT_EN
        chk({nm, ".retry_hold"}, 32'(retry_cnt_o), 32'(m_k == 0 ? 0 : m_k - 1));
`endif
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_data_i = '0;
        stuck0 = '0; load_en = 1'b1; load_val = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst.s",     32'(s_o),         32'(0));
        chk("rst.r",     32'(r_o),         32'(0));
        chk("rst.ready", 32'(req_ready_o), 32'(1));
        chk("rst.busy",  32'(busy_o | done_o | err_o), 32'(0));
        rst_i = 1'b0; load_en = 1'b0;
        @(negedge clk_i);

        load_bank(4'b0000); run_req("t2_write", 4'b1010, 1'b0);
        chk("t2.T", 32'(m_T), 32'(5));
        load_bank(4'b1010); run_req("t3_same", 4'b1010, 1'b0);
        chk("t3.T", 32'(m_T), 32'(1));
        load_bank(4'b1100); run_req("t4_mixed", 4'b0110, 1'b0);
        stuck0 = 4'b0001;
        load_bank(4'b0000); run_req("t5_stuck", 4'b0001, 1'b0);
        chk("t5.T", 32'(m_T), 32'(13));
        stuck0 = '0;

        for (int i = 0; i < 12; i++) begin
            stuck0 = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            load_bank(N'($urandom));
            run_req("rand", N'($urandom), 1'b0);
        end
        stuck0 = '0;

        // Back-to-back with reset in the DRIVE phase of the second request.
        load_bank(4'b0000);
        run_req("t6_first", 4'b0011, 1'b1);
        req_data_i = 4'b1100;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("t6.s2",    32'(s_o),    32'(4'b1100));
        chk("t6.r2",    32'(r_o),    32'(4'b0011));
        chk("t6.busy2", 32'(busy_o), 32'(1));
        #2 rst_i = 1'b1;
        #1;
        chk("t1.s",     32'(s_o),         32'(0));
        chk("t1.r",     32'(r_o),         32'(0));
        chk("t1.ready", 32'(req_ready_o), 32'(1));
        chk("t1.flags", 32'({busy_o, done_o, err_o}), 32'(0));
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("t6.ready_after", 32'(req_ready_o), 32'(1));
        chk("t6.busy_after",  32'(busy_o),      32'(0));
        chk("t6.bank_kept",   32'(q_fb_i),      32'(4'b0011));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
